// File: rtl/ones_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ones_serializer_pkg
// Shared definitions for the ones serializer:
//   - ser_state_t : FSM state encoding (IDLE, ONE, GAPS, DONE)
//   - GAP_MAX     : largest supported inter-one gap
//   - gap_w()     : width of the gap counter for a given GAP value
// ---------------------------------------------------------------------------
package ones_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    GAPS = 2'd2,
    DONE = 2'd3
  } ser_state_t;

  localparam int GAP_MAX = 15;

  // Bits needed to hold the value GAP; never narrower than one bit so the
  // tied-off counter for GAP==0 still has a legal vector width.
  function automatic int gap_w(input int gap);
    if (gap < 1) begin
      return 1;
    end else begin
      return $clog2(gap + 1);
    end
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// ---------------------------------------------------------------------------
// load_down_counter
// Loadable down counter with a zero flag. Load has priority over decrement;
// decrement stops at zero instead of wrapping.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset (count -> 0)
//   i_load     : load i_load_val this cycle
//   i_load_val : value to load
//   i_dec      : decrement by one this cycle (ignored at zero)
//   o_cnt      : current count
//   o_zero     : count equals zero
// ---------------------------------------------------------------------------
module load_down_counter
  import ones_serializer_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: reset, load, saturating decrement, hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/ones_serializer.sv
// ---------------------------------------------------------------------------
// ones_serializer
// Accepts a count N over a valid/ready handshake and emits exactly N '1'
// cycles on ser_out, each pair separated by GAP '0' cycles, then raises a
// one-cycle done pulse. N=0 goes straight to the done pulse.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high reset; abandons a burst silently
//   cnt_in    : number of ones to emit, sampled only on the handshake edge
//   cnt_valid : cnt_in valid
//   cnt_ready : block can accept a count (IDLE)
//   ser_out   : registered serial output
//   busy      : high from the cycle after accept through the done cycle
//   done      : one-cycle completion pulse
// All outputs are flops loaded from the next-state value, so none of them
// has a combinational path from an input.
// ---------------------------------------------------------------------------
module ones_serializer
  import ones_serializer_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int GW = gap_w(GAP);

  ser_state_t r_state;
  ser_state_t w_state_nxt;

  logic r_ser_out;
  logic r_busy;
  logic r_done;
  logic r_cnt_ready;

  logic             w_hs;
  logic             w_cnt_zero;
  logic             w_rem_load;
  logic             w_rem_dec;
  logic [CNT_W-1:0] w_rem_cnt;
  logic             w_rem_zero;
  logic             w_rem_last;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic [GW-1:0]    w_gap_cnt;
  logic             w_gap_zero;
  logic             w_gap_last;

  assign w_hs       = cnt_valid & r_cnt_ready;
  assign w_cnt_zero = (cnt_in == {CNT_W{1'b0}});
  assign w_rem_last = (w_rem_cnt == CNT_W'(1));
  assign w_gap_last = (w_gap_cnt == GW'(1));

  // Ones still to be emitted in the current burst.
  load_down_counter #(
    .W (CNT_W)
  ) u_rem_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rem_load),
    .i_load_val (cnt_in),
    .i_dec      (w_rem_dec),
    .o_cnt      (w_rem_cnt),
    .o_zero     (w_rem_zero)
  );

  generate
    if (GAP > 0) begin : g_gap
      // Zero cycles left before the next '1'.
      load_down_counter #(
        .W (GW)
      ) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_gap_load),
        .i_load_val (GW'(GAP)),
        .i_dec      (w_gap_dec),
        .o_cnt      (w_gap_cnt),
        .o_zero     (w_gap_zero)
      );
    end else begin : g_no_gap
      // GAPS is unreachable without a gap; hold the counter outputs idle.
      logic w_gap_unused;
      assign w_gap_unused = w_gap_load ^ w_gap_dec;
      assign w_gap_cnt    = {GW{1'b0}};
      assign w_gap_zero   = 1'b1;
    end
  endgenerate

  // Next-state and counter-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_load  = 1'b0;
    w_rem_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (w_cnt_zero) begin
            w_state_nxt = DONE;
          end else begin
            w_rem_load  = 1'b1;
            w_state_nxt = ONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ONE: begin
        w_rem_dec = 1'b1;
        // Zero is unreachable here; treating it as last keeps a corrupted
        // counter from trapping the FSM in ONE.
        if (w_rem_last || w_rem_zero) begin
          w_state_nxt = DONE;
        end else if (GAP > 0) begin
          w_gap_load  = 1'b1;
          w_state_nxt = GAPS;
        end else begin
          w_state_nxt = ONE;
        end
      end
      GAPS: begin
        w_gap_dec = 1'b1;
        if (w_gap_last || w_gap_zero) begin
          w_state_nxt = ONE;
        end else begin
          w_state_nxt = GAPS;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ser_out   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_ser_out   <= (w_state_nxt == ONE);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
      r_cnt_ready <= (w_state_nxt == IDLE);
    end
  end

  assign ser_out   = r_ser_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cnt_ready = r_cnt_ready;

endmodule

// File: tb/tb_ones_serializer.sv
// ---------------------------------------------------------------------------
// tb_ones_serializer
// Four serializers (GAP = 0,1,2,3, CNT_W = 3) share one clock and reset.
// Expected waveforms come from a cycle-offset model: for a burst accepted at
// edge k, a '1' appears at offsets 1 + i*(GAP+1), i < N, and done follows
// the last one.
// ---------------------------------------------------------------------------
module tb_ones_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cnt_in    [4];
  logic       cnt_valid [4];
  logic       cnt_ready [4];
  logic       ser_out   [4];
  logic       busy      [4];
  logic       done      [4];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ones_serializer #(
      .CNT_W (3),
      .GAP   (g)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cnt_in    (cnt_in[g]),
      .cnt_valid (cnt_valid[g]),
      .cnt_ready (cnt_ready[g]),
      .ser_out   (ser_out[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  // Offset of the last '1' after the accept edge (0 when N=0).
  function automatic int exp_span(input int n, input int gap);
    if (n == 0) return 0;
    return n + (n - 1) * gap;
  endfunction

  function automatic logic exp_ser(input int n, input int gap, input int c);
    if (n == 0 || c < 1 || c > exp_span(n, gap)) return 1'b0;
    return (((c - 1) % (gap + 1)) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ser_out[i], busy[i], done[i], cnt_ready[i]} !== 4'b0001) begin
        n_fails++;
        $display("FAIL reset dut%0d ser/busy/done/rdy got=%b exp=0001", i,
                 {ser_out[i], busy[i], done[i], cnt_ready[i]});
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_burst5();
    int   rx;
    int   sp;
    logic [3:0] e;
    rx = 0;
    sp = exp_span(5, 0);
    cnt_in[0] = 3'd5; cnt_valid[0] = 1'b1;
    tick();
    cnt_valid[0] = 1'b0; cnt_in[0] = 3'd0;
    for (int c = 1; c <= 7; c++) begin
      e = {exp_ser(5, 0, c), (c <= sp + 1), (c == sp + 1), (c >= sp + 2)};
      n_checks++;
      if ({ser_out[0], busy[0], done[0], cnt_ready[0]} !== e) begin
        n_fails++;
        $display("FAIL burst5 c=%0d ser/busy/done/rdy got=%b exp=%b", c,
                 {ser_out[0], busy[0], done[0], cnt_ready[0]}, e);
      end
      rx += int'(ser_out[0]);
      tick();
    end
    n_checks++;
    if (rx != 5) begin
      n_fails++;
      $display("FAIL burst5_rxcount got=%0d exp=5", rx);
    end
  endtask

  task automatic test_zero();
    logic [3:0] e;
    cnt_in[0] = 3'd0; cnt_valid[0] = 1'b1;
    tick();
    cnt_valid[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      e = {1'b0, (c == 1), (c == 1), (c >= 2)};
      n_checks++;
      if ({ser_out[0], busy[0], done[0], cnt_ready[0]} !== e) begin
        n_fails++;
        $display("FAIL zero c=%0d ser/busy/done/rdy got=%b exp=%b", c,
                 {ser_out[0], busy[0], done[0], cnt_ready[0]}, e);
      end
      tick();
    end
  endtask

  task automatic test_gap2();
    logic [7:0] pat;
    logic [7:0] e_pat;
    // offsets 1..8: 1,0,0,1,0,0,1 then done at 8 (ser low)
    e_pat = 8'b0100_1001;
    pat = 8'b0;
    cnt_in[2] = 3'd3; cnt_valid[2] = 1'b1;
    tick();
    cnt_valid[2] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      pat[c-1] = ser_out[2];
      n_checks++;
      if (done[2] !== (c == 8)) begin
        n_fails++;
        $display("FAIL gap2_done c=%0d got=%b exp=%b", c, done[2], (c == 8));
      end
      tick();
    end
    n_checks++;
    if (pat !== e_pat) begin
      n_fails++;
      $display("FAIL gap2_pattern got=%b exp=%b", pat, e_pat);
    end
  endtask

  task automatic test_back_to_back();
    int rx;
    logic [3:0] e;
    logic e_ser;
    logic e_done;
    logic e_rdy;
    rx = 0;
    cnt_in[0] = 3'd7; cnt_valid[0] = 1'b1;
    tick();
    for (int c = 1; c <= 13; c++) begin
      e_ser  = (c >= 1 && c <= 7) || (c == 10) || (c == 11);
      e_done = (c == 8) || (c == 12);
      e_rdy  = (c == 9) || (c == 13);
      e = {e_ser, !e_rdy, e_done, e_rdy};
      n_checks++;
      if ({ser_out[0], busy[0], done[0], cnt_ready[0]} !== e) begin
        n_fails++;
        $display("FAIL b2b c=%0d ser/busy/done/rdy got=%b exp=%b", c,
                 {ser_out[0], busy[0], done[0], cnt_ready[0]}, e);
      end
      rx += int'(ser_out[0]);
      if (c == 3) cnt_in[0] = 3'd2;
      if (c == 10) cnt_valid[0] = 1'b0;
      tick();
    end
    n_checks++;
    if (rx != 9) begin
      n_fails++;
      $display("FAIL b2b_rxcount got=%0d exp=9", rx);
    end
  endtask

  task automatic test_reset_mid();
    cnt_in[0] = 3'd6; cnt_valid[0] = 1'b1;
    tick();
    cnt_valid[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (ser_out[0] !== 1'b1) begin
        n_fails++;
        $display("FAIL rstmid_pre c=%0d ser got=%b exp=1", c, ser_out[0]);
      end
      if (c < 3) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({ser_out[0], busy[0], done[0], cnt_ready[0]} !== 4'b0001) begin
      n_fails++;
      $display("FAIL rstmid_after ser/busy/done/rdy got=%b exp=0001",
               {ser_out[0], busy[0], done[0], cnt_ready[0]});
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if ({ser_out[0], done[0]} !== 2'b00) begin
        n_fails++;
        $display("FAIL rstmid_quiet c=%0d ser/done got=%b exp=00", c, {ser_out[0], done[0]});
      end
    end
  endtask

  task automatic test_random();
    int idx, n, ones, bad, c, done_at, done_cnt, sel;
    bit seen;
    done_cnt = 0;
    for (int b = 0; b < 200; b++) begin
      sel = int'($urandom_range(0, 2));
      idx = (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
      n   = int'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) begin
        cnt_in[idx] = 3'($urandom_range(0, 7));
        tick();
      end
      cnt_in[idx] = 3'(n); cnt_valid[idx] = 1'b1;
      tick();
      cnt_valid[idx] = 1'b0;
      ones = 0; bad = 0; c = 1; seen = 1'b0; done_at = -1;
      while (c <= 40 && !seen) begin
        if (ser_out[idx] !== exp_ser(n, idx, c)) bad++;
        if (c == 2) cnt_in[idx] = 3'($urandom_range(0, 7));
        ones += int'(ser_out[idx]);
        if (done[idx] === 1'b1) begin
          seen = 1'b1;
          done_cnt++;
          done_at = c;
        end
        tick();
        c++;
      end
      n_checks++;
      if (!seen) begin
        n_fails++;
        $display("FAIL rand_timeout burst=%0d gap=%0d n=%0d no done within 40 cycles", b, idx, n);
      end
      n_checks++;
      if (ones != n) begin
        n_fails++;
        $display("FAIL rand_ones burst=%0d gap=%0d got=%0d exp=%0d", b, idx, ones, n);
      end
      n_checks++;
      if (done_at != exp_span(n, idx) + 1) begin
        n_fails++;
        $display("FAIL rand_done_cycle burst=%0d gap=%0d n=%0d got=%0d exp=%0d", b, idx, n,
                 done_at, exp_span(n, idx) + 1);
      end
      n_checks++;
      if (bad != 0) begin
        n_fails++;
        $display("FAIL rand_pattern burst=%0d gap=%0d n=%0d bad_cycles got=%0d exp=0", b, idx, n, bad);
      end
      n_checks++;
      if (cnt_ready[idx] !== 1'b1) begin
        n_fails++;
        $display("FAIL rand_ready burst=%0d gap=%0d got=%b exp=1", b, idx, cnt_ready[idx]);
      end
    end
    n_checks++;
    if (done_cnt != 200) begin
      n_fails++;
      $display("FAIL rand_done_total got=%0d exp=200", done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      cnt_in[i]    = 3'd0;
      cnt_valid[i] = 1'b0;
    end
    test_reset();
    test_burst5();
    test_zero();
    test_gap2();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ones_serializer.md
Name: ones_serializer

Overview:
- Transmit-side counterpart of the team's serial ones-counter.
- Accepts a count N over a valid/ready handshake and drives exactly N '1' bits onto a registered serial line, optionally separated by GAP '0' bits.
- Signals completion with a one-cycle done pulse.
- A downstream ones-counter reset before the burst reads back N once the burst finishes.

Parameters:
- CNT_W, 3, width of count input; max burst = 2**CNT_W-1 ones
- GAP, 0, number of '0' cycles inserted between consecutive '1' bits (0 = back-to-back ones); legal range 0..15

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cnt_in  input  CNT_W  number of ones to emit, sampled only on handshake
- cnt_valid  input  1  cnt_in valid
- cnt_ready  output  1  block can accept a count
- ser_out  output  1  serial output, registered
- busy  output  1  high from cycle after accept until the done cycle inclusive
- done  output  1  one-cycle pulse after last bit (or after accept of N=0)

Behaviour:
- Clocking and reset: one clock clk. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: state=IDLE, ser_out=0, busy=0, done=0, cnt_ready=1, remaining=0, gap counter=0.
- Reset mid-burst: the burst is abandoned with no done pulse. The cycle after reset is sampled, IDLE and ser_out=0.
- FSM states (enum in package): IDLE, ONE, GAPS, DONE.
- IDLE:
  - cnt_ready=1, ser_out=0.
  - Handshake occurs at the edge where cnt_valid&&cnt_ready.
  - If cnt_in==0, go to DONE.
  - Otherwise load remaining=cnt_in and go to ONE.
- ONE:
  - ser_out=1 for exactly one cycle; remaining decrements at the end of the cycle.
  - If remaining==1: go to DONE.
  - Else if GAP>0: load gap counter=GAP and go to GAPS.
  - Else stay in ONE.
- GAPS: ser_out=0; gap counter decrements; go to ONE when it reaches 1 (exactly GAP zero cycles).
- DONE: done=1, busy=1, ser_out=0, cnt_ready=0 for one cycle, then IDLE.
- cnt_ready is 0 in ONE, GAPS and DONE; no back-to-back acceptance, so a new count is accepted earliest one cycle after done.
- cnt_in is ignored outside the handshake edge; a change to cnt_in mid-burst has no effect.
- Timing with handshake at edge k, N>0:
  - ser_out=1 in cycles k+1 .. k+N+(N-1)*GAP (ones at spacing GAP+1).
  - done in the next cycle; cnt_ready=1 in the cycle after that.
  - N=0: done in cycle k+1, ser_out never high.
- Total '1' cycles per burst = N exactly; max N=2**CNT_W-1, with no saturation needed since the input width bounds it.
- ser_out, done, cnt_ready and busy are decoded from registered state only (glitch-free, no combinational path from inputs to outputs).

Decomposition:
- Package ones_serializer_pkg: state enum ser_state_t {IDLE, ONE, GAPS, DONE} as logic [1:0]; GAP_W localparam function (clog2 of GAP+1).
- One sub-module is natural: load_down_counter (parameterised width; load, dec, zero flag).
  - Instantiate twice: remaining-ones counter and gap counter.
  - The gap counter instance is tied off when GAP==0.

Test Plan:
- Reset then cnt_in=5, cnt_valid=1 for one cycle, GAP=0 -> ser_out high exactly cycles k+1..k+5; done pulse at k+6; cnt_ready=1 at k+7; a ones-counter fed by ser_out reads 5.
- cnt_in=0 accepted at k -> ser_out stays 0; done at k+1; cnt_ready at k+2.
- GAP=2, cnt_in=3 -> ser_out pattern 1,0,0,1,0,0,1 starting k+1; done at k+8.
- cnt_in=7 (max), with cnt_valid held high and cnt_in changed to 2 mid-burst -> seven ones emitted; second handshake (value 2) occurs only at the first cycle cnt_ready=1 after done; then two ones.
- Reset asserted during the 3rd '1' of a 6-burst -> next cycle ser_out=0, cnt_ready=1, busy=0, no done pulse.
- Random N in 0..7 and GAP in {0,1,3}, 200 bursts -> ones count per burst == N and done count == bursts; receiver model matches every burst.
